// File: rtl/loadalign_rv32i.sv
// rtl/loadalign_rv32i.sv - load unit: aligned reads, extract and extend; macro LOADALIGN_SPLIT_EN enables misaligned (split) loads
module loadalign_rv32i #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_type,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;

  state_t            state, state_nx;
  logic [OFF_W-1:0]  off_q, req_off;
  logic [2:0]        type_q;
  logic [TAG_W-1:0]  tag_q, tag_hold;
  logic              err_q;
  logic [XLEN-1:0]   beat0_q, beat1_q, data_hold, result;
  logic [ADDR_W-1:0] aligned;
  logic [3:0]        size_b;
  logic              illegal_type, bad;
`ifdef LOADALIGN_SPLIT_EN
  logic              cross, split_q;
`else
  logic [2:0]        size_m;
  logic              misal;
`endif

  // Decode size, legality and the aligned address of the incoming request
  always_comb begin
    size_b       = 4'd1 << req_type[1:0];
    req_off      = req_addr[OFF_W-1:0];
    aligned      = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    illegal_type = (req_type == 3'b111) ||
                   ((XLEN == 32) && ((req_type == 3'b011) || (req_type == 3'b110)));
`ifdef LOADALIGN_SPLIT_EN
    cross        = (int'(req_off) + int'(size_b)) > NB;
    bad          = illegal_type;
`else
    size_m       = 3'(size_b - 4'd1);
    misal        = |(req_addr[2:0] & size_m);
    bad          = illegal_type || misal;
`endif
  end

  // Shift the two-beat window down by the byte offset, then trim and extend to the field size
  always_comb begin
    logic [XLEN-1:0] low, left;
    logic [6:0]      sa;
    low  = XLEN'({beat1_q, beat0_q} >> {off_q, 3'b000});
    sa   = 7'(XLEN) - (7'd8 << type_q[1:0]);
    left = low << sa;
    if (err_q)          result = '0;
    else if (type_q[2]) result = left >> sa;
    else                result = XLEN'($signed(left) >>> sa);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (req_valid) state_nx = bad ? RESP : ISSUE0;
      ISSUE0: if (mem_req_ready) state_nx = WAIT0;
`ifdef LOADALIGN_SPLIT_EN
      WAIT0:  if (mem_rsp_valid) state_nx = split_q ? ISSUE1 : RESP;
      ISSUE1: if (mem_req_ready) state_nx = WAIT1;
      WAIT1:  if (mem_rsp_valid) state_nx = RESP;
`else
      WAIT0:  if (mem_rsp_valid) state_nx = RESP;
`endif
      RESP:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake and response outputs; result and tag are held between responses
  always_comb begin
    req_ready     = rst_n && (state == IDLE);
    mem_req_valid = (state == ISSUE0) || (state == ISSUE1);
    rsp_valid     = (state == RESP);
    rsp_err       = (state == RESP) && err_q;
    rsp_data      = (state == RESP) ? result : data_hold;
    rsp_tag       = (state == RESP) ? tag_q : tag_hold;
  end

  // Request capture, beat capture and response hold registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q        <= '0;
      type_q       <= '0;
      tag_q        <= '0;
      err_q        <= 1'b0;
      beat0_q      <= '0;
      beat1_q      <= '0;
      mem_req_addr <= '0;
      data_hold    <= '0;
      tag_hold     <= '0;
`ifdef LOADALIGN_SPLIT_EN
      split_q      <= 1'b0;
`endif
    end else begin
      if (state == IDLE && req_valid) begin
        off_q        <= req_off;
        type_q       <= req_type;
        tag_q        <= req_tag;
        err_q        <= bad;
        beat0_q      <= '0;
        beat1_q      <= '0;
        mem_req_addr <= aligned;
`ifdef LOADALIGN_SPLIT_EN
        split_q      <= cross;
`endif
      end
      if (state == WAIT0 && mem_rsp_valid) begin
        beat0_q <= mem_rsp_data;
`ifdef LOADALIGN_SPLIT_EN
        if (split_q) mem_req_addr <= mem_req_addr + ADDR_W'(NB);
`endif
      end
      if (state == WAIT1 && mem_rsp_valid) beat1_q <= mem_rsp_data;
      if (state == RESP) begin
        data_hold <= result;
        tag_hold  <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_loadalign_rv32i.sv
// tb/tb_loadalign_rv32i.sv - self-checking bench for loadalign_rv32i (XLEN=32)
module tb_loadalign_rv32i;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_type;
  logic [4:0]  req_tag;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_tag;
  logic        rsp_err;

  loadalign_rv32i #(.XLEN(32), .ADDR_W(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_type(req_type), .req_tag(req_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stall_left = 0;
  int rsp_delay = 0;
  logic [31:0] acc_q[$];

  int          obs_lat;
  logic [31:0] obs_data, after_data;
  logic        obs_err, after_valid, after_err;
  logic [4:0]  obs_tag;
  logic        rdy_at_accept, busy_ready_bad, addr_unstable;

  typedef struct {
    logic [2:0]  t;
    logic [31:0] a;
    logic [4:0]  tag;
    int          stall;
    int          dly;
    logic [31:0] d;
    logic        e;
    int          n;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mb(input logic [31:0] a);
    case (a)
      32'h100: return 8'hEF;
      32'h101: return 8'hBE;
      32'h102: return 8'hAD;
      32'h103: return 8'hDE;
      32'h104: return 8'h44;
      32'h105: return 8'h33;
      32'h106: return 8'h22;
      32'h107: return 8'h11;
      default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
  endfunction

  // Byte-level reference: gather the bytes, then sign or zero extend arithmetically
  function automatic void model(input logic [2:0] t, input logic [31:0] a,
                                output logic [31:0] d, output logic e, output int n);
    int     size;
    longint v;
    size = 1 << t[1:0];
    e = (t == 3'b111) || (t == 3'b011) || (t == 3'b110);
`ifndef LOADALIGN_SPLIT_EN
    if ((a % size) != 0) e = 1'b1;
`endif
    if (e) begin
      d = '0;
      n = 0;
      return;
    end
    v = 0;
    for (int i = 0; i < size; i++) v += longint'(mb(a + 32'(i))) << (8 * i);
    if (!t[2] && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
    d = v[31:0];
    n = (int'(a % 4) + size > 4) ? 2 : 1;
  endfunction

  // Memory: stalls the first request by stall_left cycles, answers after rsp_delay cycles
  initial begin : mem_proc
    logic [31:0] ha;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        ha = mem_req_addr;
        repeat (rsp_delay) @(posedge clk);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = word(ha);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = $urandom;
      end else begin
        if (mem_req_valid && !mem_req_ready && stall_left > 0) stall_left--;
        @(posedge clk); #1;
        mem_req_ready = (stall_left == 0);
      end
    end
  end

  task automatic do_load(input logic [2:0] t, input logic [31:0] a, input logic [4:0] tag,
                         input int stall, input int dly);
    logic        have_prev, prev_rdy;
    logic [31:0] prev_addr;
    stall_left = stall;
    rsp_delay  = dly;
    acc_q.delete();
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_type = t; req_tag = tag;
    @(negedge clk);
    rdy_at_accept = req_ready;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_type = 3'($urandom); req_tag = 5'($urandom);
    obs_lat = -1; busy_ready_bad = 1'b0; addr_unstable = 1'b0;
    have_prev = 1'b0; prev_rdy = 1'b1; prev_addr = '0;
    obs_data = '0; obs_err = 1'b0; obs_tag = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (req_ready) busy_ready_bad = 1'b1;
      if (mem_req_valid && have_prev && !prev_rdy && mem_req_addr !== prev_addr) addr_unstable = 1'b1;
      have_prev = mem_req_valid; prev_rdy = mem_req_ready; prev_addr = mem_req_addr;
      if (mem_req_valid && mem_req_ready) acc_q.push_back(mem_req_addr);
      if (rsp_valid) begin
        obs_lat = k; obs_data = rsp_data; obs_err = rsp_err; obs_tag = rsp_tag;
        break;
      end
    end
    @(negedge clk);
    after_valid = rsp_valid; after_err = rsp_err; after_data = rsp_data;
  endtask

  task automatic run_check(input string name, input logic [2:0] t, input logic [31:0] a,
                           input logic [4:0] tag, input int stall, input int dly,
                           input logic [31:0] ed, input logic ee, input int en);
    int exp_lat;
    do_load(t, a, tag, stall, dly);
    if (ee) check({name, "_errlat"}, 64'((obs_lat >= 1) && (obs_lat <= 2)), 64'd1);
    else begin
      exp_lat = 3 + stall + dly + ((en == 2) ? (2 + dly) : 0);
      check({name, "_lat"}, 64'(obs_lat), 64'(exp_lat));
    end
    check({name, "_data"}, 64'(obs_data), 64'(ed));
    check({name, "_err"}, 64'(obs_err), 64'(ee));
    check({name, "_tag"}, 64'(obs_tag), 64'(tag));
    check({name, "_nacc"}, 64'(acc_q.size()), 64'(en));
    if (en >= 1 && acc_q.size() >= 1) check({name, "_addr0"}, 64'(acc_q[0]), 64'(a & 32'hFFFF_FFFC));
    if (en == 2 && acc_q.size() >= 2) check({name, "_addr1"}, 64'(acc_q[1]), 64'((a & 32'hFFFF_FFFC) + 32'd4));
    check({name, "_rdy_accept"}, 64'(rdy_at_accept), 64'd1);
    check({name, "_busy_ready"}, 64'(busy_ready_bad), 64'd0);
    check({name, "_addr_stable"}, 64'(addr_unstable), 64'd0);
    check({name, "_pulse"}, 64'(after_valid), 64'd0);
    check({name, "_err_clr"}, 64'(after_err), 64'd0);
    check({name, "_hold"}, 64'(after_data), 64'(ed));
  endtask

  initial begin : main
    logic [31:0] md, ra;
    logic        me, bad_rsp, bad_mreq, bad_rdy;
    int          mn;
    logic [2:0]  rt;

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_type = '0; req_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    check("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready", 64'(req_ready), 64'd1);

    tbl.push_back('{3'b010, 32'h100, 5'd3,  0, 0, 32'hDEADBEEF, 1'b0, 1});
    tbl.push_back('{3'b000, 32'h103, 5'd4,  0, 0, 32'hFFFFFFDE, 1'b0, 1});
    tbl.push_back('{3'b100, 32'h103, 5'd5,  0, 0, 32'h000000DE, 1'b0, 1});
    tbl.push_back('{3'b101, 32'h102, 5'd6,  0, 0, 32'h0000DEAD, 1'b0, 1});
    tbl.push_back('{3'b001, 32'h100, 5'd7,  0, 0, 32'hFFFFBEEF, 1'b0, 1});
    tbl.push_back('{3'b010, 32'h100, 5'd8,  4, 0, 32'hDEADBEEF, 1'b0, 1});
    tbl.push_back('{3'b010, 32'h104, 5'd9,  0, 2, 32'h11223344, 1'b0, 1});
    tbl.push_back('{3'b011, 32'h100, 5'd10, 0, 0, 32'h00000000, 1'b1, 0});
    tbl.push_back('{3'b111, 32'h100, 5'd11, 0, 0, 32'h00000000, 1'b1, 0});
    tbl.push_back('{3'b110, 32'h100, 5'd12, 0, 0, 32'h00000000, 1'b1, 0});
    tbl.push_back('{3'b000, 32'h107, 5'd13, 0, 1, 32'h00000011, 1'b0, 1});
`ifdef LOADALIGN_SPLIT_EN
    tbl.push_back('{3'b010, 32'h102, 5'd14, 0, 0, 32'h3344DEAD, 1'b0, 2});
    tbl.push_back('{3'b001, 32'h101, 5'd15, 0, 0, 32'hFFFFADBE, 1'b0, 1});
    tbl.push_back('{3'b101, 32'h103, 5'd16, 1, 1, 32'h000044DE, 1'b0, 2});
`else
    tbl.push_back('{3'b010, 32'h102, 5'd14, 0, 0, 32'h00000000, 1'b1, 0});
    tbl.push_back('{3'b001, 32'h101, 5'd15, 0, 0, 32'h00000000, 1'b1, 0});
    tbl.push_back('{3'b101, 32'h103, 5'd16, 1, 1, 32'h00000000, 1'b1, 0});
`endif
    for (int i = 0; i < tbl.size(); i++)
      run_check($sformatf("vec%0d", i), tbl[i].t, tbl[i].a, tbl[i].tag, tbl[i].stall,
                tbl[i].dly, tbl[i].d, tbl[i].e, tbl[i].n);

    // Reset while waiting for read data, then a stale response arrives in IDLE
    run_check("pre_rst", 3'b010, 32'h100, 5'd21, 0, 0, 32'hDEADBEEF, 1'b0, 1);
    stall_left = 0; rsp_delay = 3;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h104; req_type = 3'b010; req_tag = 5'd22;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_seq_issue", 64'(mem_req_valid), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", 64'(req_ready), 64'd0);
    check("midrst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("midrst_mem_req_addr", 64'(mem_req_addr), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_rsp_err", 64'(rsp_err), 64'd0);
    check("midrst_rsp_data", 64'(rsp_data), 64'd0);
    check("midrst_rsp_tag", 64'(rsp_tag), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad_rsp = 1'b0; bad_mreq = 1'b0; bad_rdy = 1'b0;
    repeat (7) begin
      @(negedge clk);
      if (rsp_valid) bad_rsp = 1'b1;
      if (mem_req_valid) bad_mreq = 1'b1;
      if (!req_ready) bad_rdy = 1'b1;
    end
    check("stale_no_rsp", 64'(bad_rsp), 64'd0);
    check("stale_no_mreq", 64'(bad_mreq), 64'd0);
    check("post_rst_ready", 64'(bad_rdy), 64'd0);
    run_check("post_rst_load", 3'b100, 32'h106, 5'd23, 0, 0, 32'h00000022, 1'b0, 1);

    // Randomised loads against the byte-level model
    for (int i = 0; i < 150; i++) begin
      rt = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0:       ra = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
        1:       ra = $urandom;
        default: ra = 32'h100 + 32'($urandom_range(0, 255));
      endcase
      model(rt, ra, md, me, mn);
      run_check($sformatf("rnd%0d", i), rt, ra, 5'($urandom), $urandom_range(0, 2),
                $urandom_range(0, 2), md, me, mn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
